vga_sprite_engine: RTL
======================

Name: vga_sprite_engine

Overview:
Parametrised successor to the fixed 800x600 VGA generator. Generates programmable-timing VGA sync and blits one IMG_W x IMG_H RGB332 image from an external synchronous ROM at a runtime-movable position, with a colour-key transparency and configurable background. Sits between the pixel clock domain and the VGA DAC pins; the ROM module is instantiated outside the block.

Parameters:
H_VIS, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width
H_BP, 88, horizontal back porch
V_VIS, 600, visible lines
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BP, 23, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
IMG_W, 168, sprite width
IMG_H, 192, sprite height
AW, 16, ROM address width (IMG_W*IMG_H <= 2^AW)
KEY_COLOR, 8'hE3, sprite pixel value treated as transparent

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
sprite_x  in  11  sprite left column, sampled once per frame
sprite_y  in  10  sprite top line, sampled once per frame
bg_color  in  8  RGB332 background inside visible area
rom_addr  out  AW  sprite ROM address
rom_data  in  8  ROM data, valid 1 clk after rom_addr
red  out  3  rgb[7:5]
green  out  3  rgb[4:2]
blue  out  2  rgb[1:0]
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_start  out  1  1-clk pulse aligned with first visible pixel on pins

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: hcount=0, vcount=0, rom_addr=0, rgb=0, hsync=vsync=inactive (~SYNC_POL), frame_start=0, latched position=0, row_base=0.
- H_TOT=H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise. hcount wraps H_TOT-1->0; vcount increments on h wrap and wraps V_TOT-1->0.
- Sync (stage 0): hsync active for H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC; vsync likewise on vcount.
- Position latch: sprite_x/sprite_y are sampled into xl/yl when hcount=H_TOT-1 and vcount=V_TOT-1. Mid-frame changes have no effect until the next frame, so there is no tearing.
- Window: in_win = xl <= hcount < xl+IMG_W and yl <= vcount < yl+IMG_H and visible. Compare widths are widened by 1 bit, so xl+IMG_W never wraps.
- Address: rom_addr = row_base + (hcount - xl), registered (stage 1).
- row_base clears at frame start. It adds IMG_W at h wrap when yl <= vcount < yl+IMG_H.
- Clipping at right/bottom edges: pixels are simply not shown. Addressing stays correct because the column is derived from hcount.
- Pixel (stage 2): visible and in_win and rom_data!=KEY_COLOR -> rom_data; visible and not displayed as sprite -> bg_color; blanking -> 8'h00.
- Latency: 2 clk from counter state to pins. hsync, vsync and the visible/in_win flags are delayed through matching 2-stage pipes so all outputs align.
- frame_start: asserted at pins together with pixel (0,0).
- Sprite fully offscreen (xl>=H_VIS or yl>=V_VIS): frame is all bg_color; rom_addr still driven but ignored.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). The first frame after release starts at (0,0) with position 0 until the first latch.

Optional Feature:
VGA_SPRITE_SCALE2X_EN
- Defined: sprite is displayed at 2x in both axes.
- Window extends to 2*IMG_W x 2*IMG_H.
- Column = (hcount-xl)>>1.
- row_base advances IMG_W only after every second sprite line (line-parity bit).
- Not defined: 1x only, no parity logic synthesised.

Test Plan:
1. Reset released, default params -> hsync active-low for hcount 840..967; vsync low for vcount 601..604; frame period exactly 1056*628 clk.
2. sprite_x=10, sprite_y=10, ROM[i]=i[7:0] -> pixel (10,10) shows 8'h00; (11,10) shows 8'h01; (10,11) shows IMG_W[7:0]=8'hA8; (9,10) and (178,10) show bg_color.
3. ROM[0]=KEY_COLOR, bg_color=8'h1C -> pixel (10,10) outputs 8'h1C; (11,10) outputs ROM[1].
4. sprite_x=700 -> column 799 shows ROM[99]; column 800 is blanked to 0; next row starts at ROM[168].
5. sprite_x changed 10->50 at vcount=300 -> rest of frame unchanged; next frame sprite begins at column 50; frame_start pulses once per frame at pixel (0,0).
6. reset_n pulled low at hcount=400, vcount=200 -> rgb=0 and syncs inactive in the same cycle without a clock edge; after release, hcount/vcount restart at 0. With VGA_SPRITE_SCALE2X_EN, pixels (10,10),(11,10),(10,11),(11,11) all equal ROM[0].

Source files
------------

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: programmable-timing VGA sync generator that blits one
// IMG_W x IMG_H RGB332 sprite from an external ROM at a per-frame position,
// with colour-key transparency and a configurable background.
// Optional macro VGA_SPRITE_SCALE2X_EN: display the sprite at 2x in both axes.
// Pipeline: stage 0 = counters, stage 1 = ROM address and flags, stage 2 = pins.
// The rom_addr register acts as the ROM's address register, so rom_data is
// valid during the cycle after the address was computed.
module vga_sprite_engine #(
    parameter int unsigned H_VIS     = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VIS     = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned IMG_W     = 168,
    parameter int unsigned IMG_H     = 192,
    parameter int unsigned AW        = 16,
    parameter logic [7:0]  KEY_COLOR = 8'hE3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   sprite_x,
    input  logic [9:0]    sprite_y,
    input  logic [7:0]    bg_color,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [2:0]    red,
    output logic [2:0]    green,
    output logic [1:0]    blue,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    // Compare widths: one bit wider than the position ports so x+W never wraps
    localparam int unsigned XW    = 12;
    localparam int unsigned YW    = 11;
`ifdef VGA_SPRITE_SCALE2X_EN
    localparam int unsigned SCALE = 2;
`else
    localparam int unsigned SCALE = 1;
`endif
    localparam int unsigned WIN_W = IMG_W * SCALE;
    localparam int unsigned WIN_H = IMG_H * SCALE;
    localparam logic        SYNC_ACT = 1'(SYNC_POL);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [10:0]   xl;
    logic [9:0]    yl;
    logic [AW-1:0] row_base;

    logic          h_last, v_last;
    logic [XW-1:0] h_ext, x_lo, x_hi, col_off;
    logic [YW-1:0] v_ext, y_lo, y_hi;
    logic          visible, col_in, row_in, in_win, row_adv;
    logic          hs_c, vs_c, fs_c;
    logic [AW-1:0] col, addr_c;

    logic          hs1, vs1, vis1, win1, fs1;
    logic [7:0]    pix_c;

    // Stage 0 decode: window, sync and address from the current counters
    always_comb begin
        h_last  = (hcount == HW'(H_TOT - 1));
        v_last  = (vcount == VW'(V_TOT - 1));
        h_ext   = XW'(hcount);
        v_ext   = YW'(vcount);
        x_lo    = XW'(xl);
        x_hi    = x_lo + XW'(WIN_W);
        y_lo    = YW'(yl);
        y_hi    = y_lo + YW'(WIN_H);
        visible = (h_ext < XW'(H_VIS)) && (v_ext < YW'(V_VIS));
        col_in  = (h_ext >= x_lo) && (h_ext < x_hi);
        row_in  = (v_ext >= y_lo) && (v_ext < y_hi);
        in_win  = visible && col_in && row_in;
        col_off = h_ext - x_lo;
`ifdef VGA_SPRITE_SCALE2X_EN
        col     = AW'(col_off >> 1);
        // Advance only after the second copy of each sprite line
        row_adv = row_in && (v_ext[0] ^ y_lo[0]);
`else
        col     = AW'(col_off);
        row_adv = row_in;
`endif
        addr_c  = row_base + col;
        hs_c    = ((h_ext >= XW'(H_VIS + H_FP)) && (h_ext < XW'(H_VIS + H_FP + H_SYNC)))
                  ? SYNC_ACT : ~SYNC_ACT;
        vs_c    = ((v_ext >= YW'(V_VIS + V_FP)) && (v_ext < YW'(V_VIS + V_FP + V_SYNC)))
                  ? SYNC_ACT : ~SYNC_ACT;
        fs_c    = (hcount == '0) && (vcount == '0);
    end

    // Raster counters: hcount wraps per line, vcount steps on each line wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Sprite position is latched only at the frame boundary to avoid tearing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xl <= '0;
            yl <= '0;
        end else if (h_last && v_last) begin
            xl <= sprite_x;
            yl <= sprite_y;
        end
    end

    // ROM row base: cleared at frame start, steps one sprite row per line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
        end else if (h_last && v_last) begin
            row_base <= '0;
        end else if (h_last && row_adv) begin
            row_base <= row_base + AW'(IMG_W);
        end
    end

    // Stage 1: registered ROM address plus matching sync/flag pipe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            hs1      <= ~SYNC_ACT;
            vs1      <= ~SYNC_ACT;
            vis1     <= 1'b0;
            win1     <= 1'b0;
            fs1      <= 1'b0;
        end else begin
            rom_addr <= addr_c;
            hs1      <= hs_c;
            vs1      <= vs_c;
            vis1     <= visible;
            win1     <= in_win;
            fs1      <= fs_c;
        end
    end

    // Pixel select: sprite unless keyed out, else background, black in blanking
    always_comb begin
        pix_c = 8'h00;
        if (vis1) begin
            if (win1 && (rom_data != KEY_COLOR)) begin
                pix_c = rom_data;
            end else begin
                pix_c = bg_color;
            end
        end
    end

    // Stage 2: output pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            frame_start <= 1'b0;
        end else begin
            red         <= pix_c[7:5];
            green       <= pix_c[4:2];
            blue        <= pix_c[1:0];
            hsync       <= hs1;
            vsync       <= vs1;
            frame_start <= fs1;
        end
    end

endmodule
